// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for instruction fetch: bubble PC, NOP word,
// fetch FSM state encoding and the IF/ID payload layout.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Invalid PC the PC register drives during control hazards; never fetched.
  localparam logic [XLEN-1:0] BUBBLE_PC = 32'hffff_ff00;
  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifid_t;

  function automatic ifid_t bubble_ifid();
    return '{valid: 1'b0, pc: BUBBLE_PC, instr: NOP_INSTR};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry pc/instr holding register used while IF/ID is stalled.
// Ports: load captures pc_d/instr_d; unload and clear empty the entry
// (unload when handed to IF/ID, clear when flushed); valid_q/pc_q/instr_q
// present the held entry.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] instr_d,
  output logic            valid_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] instr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= BUBBLE_PC;
      instr_q <= NOP_INSTR;
    end else if (clear || unload) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: fetches pc_i over a req/gnt/rvalid memory
// handshake and drives the IF/ID register, inserting NOP bubbles for the
// bubble PC and branch flushes and parking responses in a skid register
// during load-use stalls.
// Ports: pc_i/npc_o/fetch_busy_o to the PC register; stall_i,
// branch_taken_i/branch_target_i from the hazard unit and EX; imem_* memory
// handshake; id_valid_o/id_pc_o/id_instr_o IF/ID contents.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] npc_o,
  output logic            fetch_busy_o,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o
);

  fetch_state_e    state_q, state_d;
  ifid_t           ifid_q, ifid_d;
  logic            ifid_load;
  logic [XLEN-1:0] req_pc_q;
  logic            redir_v_q;
  logic [XLEN-1:0] redir_pc_q;
  logic            pc_is_bubble;
  logic            req_c;
  logic            busy_c;
  logic            skid_load, skid_unload, skid_clear;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;

  assign pc_is_bubble = (pc_i == BUBBLE_PC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush beats stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_c && imem_gnt_i) state_d = WAIT;
      WAIT: begin
        // A flush coinciding with rvalid consumes that response directly
        if (branch_taken_i)     state_d = imem_rvalid_i ? IDLE : DROP;
        else if (imem_rvalid_i) state_d = stall_i ? HOLD : IDLE;
      end
      DROP: if (imem_rvalid_i) state_d = IDLE;
      HOLD: if (branch_taken_i || !stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: memory request, PC hold, IF/ID and skid control
  always_comb begin
    req_c       = 1'b0;
    busy_c      = 1'b0;
    ifid_load   = 1'b0;
    ifid_d      = ifid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps the request quiet while reset is held
        req_c  = rst_n && !pc_is_bubble && !stall_i && !branch_taken_i;
        // Hold the PC from request through grant until the word returns
        busy_c = req_c;
        if (!stall_i && pc_is_bubble) begin
          ifid_load = 1'b1;
          ifid_d    = bubble_ifid();
        end
      end
      WAIT: begin
        busy_c = !imem_rvalid_i;
        if (imem_rvalid_i && !branch_taken_i) begin
          if (stall_i) begin
            skid_load = 1'b1;
          end else begin
            ifid_load = 1'b1;
            ifid_d    = '{valid: 1'b1, pc: req_pc_q, instr: imem_rdata_i};
          end
        end
      end
      DROP: busy_c = !imem_rvalid_i;
      HOLD: begin
        // Drop the hold on the release cycle so the PC advances with IF/ID
        busy_c = stall_i;
        if (branch_taken_i) begin
          skid_clear = 1'b1;
        end else if (!stall_i) begin
          skid_unload = 1'b1;
          ifid_load   = 1'b1;
          ifid_d      = '{valid: skid_valid, pc: skid_pc, instr: skid_instr};
        end
      end
      default: ;
    endcase
    if (branch_taken_i) begin
      ifid_load = 1'b1;
      ifid_d    = bubble_ifid();
    end
  end

  assign imem_req_o   = req_c;
  assign imem_addr_o  = {pc_i[XLEN-1:2], 2'b00};
  assign fetch_busy_o = busy_c;

  // PC of the outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  req_pc_q <= '0;
    else if (req_c && imem_gnt_i) req_pc_q <= pc_i;
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ifid_q <= bubble_ifid();
    else if (ifid_load) ifid_q <= ifid_d;
  end

  assign id_valid_o = ifid_q.valid;
  assign id_pc_o    = ifid_q.pc;
  assign id_instr_o = ifid_q.instr;

  // Redirect latch keeps steering npc_o until the target PC is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else if (branch_taken_i) begin
      redir_v_q  <= 1'b1;
      redir_pc_q <= branch_target_i;
    end else if (redir_v_q && (pc_i == redir_pc_q) && !busy_c) begin
      redir_v_q  <= 1'b0;
    end
  end

  assign npc_o = branch_taken_i ? branch_target_i :
                 redir_v_q      ? redir_pc_q      :
                                  pc_i + XLEN'(4);

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .pc_d    (req_pc_q),
    .instr_d (imem_rdata_i),
    .valid_q (skid_valid),
    .pc_q    (skid_pc),
    .instr_q (skid_instr)
  );

endmodule
